keypad_digit_receiver: RTL and testbench

// - Receiving end of the keypad encoder link. Samples the encoder's {bcd, loadn} pair and

---
 rtl/keypad_digit_receiver_if.sv | 9 +
 rtl/keypad_digit_receiver.sv | 106 ++++++++++
 tb/tb_keypad_digit_receiver.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_digit_receiver_if.sv
// Encoder link between the keypad encoder (master) and the digit receiver (slave).
interface keypad_digit_receiver_if;
    logic [3:0] bcd_in;
    logic       loadn_in;
    logic       enablen;

    modport master (output bcd_in, output loadn_in, input enablen);
    modport slave  (input bcd_in, input loadn_in, output enablen);
endinterface

// File: rtl/keypad_digit_receiver.sv
// Debounces the encoder {bcd, loadn} pair, accepts one digit per press and shifts it
// into a 4-digit MM:SS entry register; gates the encoder off while cooking.
module keypad_digit_receiver #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 3
) (
    input  logic                      clk,
    input  logic                      resetn,
    keypad_digit_receiver_if.slave    enc,
    input  logic                      lock,
    input  logic                      clear_entry,
    output logic [15:0]               digits,
    output logic [2:0]                digit_count,
    output logic                      key_strobe
);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       cand;
    logic [3:0]       s_bcd;
    logic             s_load;
    logic             s_lock;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_bcd       <= '0;
            s_load      <= 1'b0;
            s_lock      <= 1'b1;
            enc.enablen <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            cand        <= '0;
            digits      <= '0;
            digit_count <= '0;
            key_strobe  <= 1'b0;
        end else begin
            s_bcd       <= enc.bcd_in;
            s_load      <= enc.loadn_in;
            s_lock      <= lock;
            enc.enablen <= s_lock;
            key_strobe  <= 1'b0;

            if (s_lock) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (s_load && (s_bcd <= 4'd9)) begin
                            cand  <= s_bcd;
                            cnt   <= CNT_ONE;
                            state <= PRESS_DB;
                        end
                    end
                    PRESS_DB: begin
                        if (!s_load || (s_bcd != cand)) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else if (cnt == CNT_DONE) begin
                            // Stable for the full window: accept the digit on HELD entry.
                            state      <= HELD;
                            key_strobe <= 1'b1;
                            digits     <= {digits[11:0], cand};
                            if (digit_count < 3'd4)
                                digit_count <= digit_count + 3'd1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    HELD: begin
                        if (!s_load) begin
                            cnt   <= CNT_ONE;
                            state <= REL_DB;
                        end
                    end
                    REL_DB: begin
                        if (s_load) begin
                            state <= HELD;
                        end else if (cnt == CNT_DONE) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                endcase
            end

            // Later assignment overrides a same-cycle digit write.
            if (clear_entry) begin
                digits      <= '0;
                digit_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_digit_receiver.sv
// Directed bench for keypad_digit_receiver with hand-computed expectations.
module tb_keypad_digit_receiver;

    logic        clk = 1'b0;
    logic        resetn;
    logic        lock;
    logic        clear_entry;
    logic [15:0] digits;
    logic [2:0]  digit_count;
    logic        key_strobe;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned strobe_cnt = 0;
    int unsigned last_strobe_cyc = 0;
    int unsigned base_strobes;
    int unsigned t0;

    keypad_digit_receiver_if enc ();

    keypad_digit_receiver #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .enc         (enc.slave),
        .lock        (lock),
        .clear_entry (clear_entry),
        .digits      (digits),
        .digit_count (digit_count),
        .key_strobe  (key_strobe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (key_strobe) begin
            strobe_cnt      <= strobe_cnt + 1;
            last_strobe_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_release(input logic [3:0] d, input int unsigned hold, input int unsigned rel);
        enc.bcd_in   = d;
        enc.loadn_in = 1'b1;
        tick(hold);
        enc.loadn_in = 1'b0;
        tick(rel);
    endtask

    task automatic apply_loadn(input logic [5:0] seq);
        for (int i = 5; i >= 0; i--) begin
            enc.loadn_in = seq[i];
            tick(1);
        end
    endtask

    initial begin
        resetn       = 1'b0;
        lock         = 1'b0;
        clear_entry  = 1'b0;
        enc.bcd_in   = 4'd0;
        enc.loadn_in = 1'b0;
        tick(3);
        check("reset_digits", digits, 16'h0000);
        check("reset_count", digit_count, 3'd0);
        check("reset_enablen", enc.enablen, 1'b1);
        check("reset_strobe", key_strobe, 1'b0);

        resetn = 1'b1;
        tick(1);
        check("enablen_1cyc", enc.enablen, 1'b1);
        tick(1);
        check("enablen_2cyc", enc.enablen, 1'b0);
        tick(2);

        // Clean press of 7, latency measured from the drive cycle
        base_strobes = strobe_cnt;
        t0 = cyc;
        press_release(4'd7, 10, 10);
        check("key7_strobes", strobe_cnt - base_strobes, 1);
        check("key7_latency", last_strobe_cyc - t0, 6);
        check("key7_digits", digits, 16'h0007);
        check("key7_count", digit_count, 3'd1);

        clear_entry = 1'b1;
        tick(1);
        clear_entry = 1'b0;
        check("clear_digits", digits, 16'h0000);
        check("clear_count", digit_count, 3'd0);

        press_release(4'd1, 8, 8);
        press_release(4'd2, 8, 8);
        press_release(4'd3, 8, 8);
        press_release(4'd0, 8, 8);
        check("four_digits", digits, 16'h1230);
        check("four_count", digit_count, 3'd4);
        press_release(4'd5, 8, 8);
        check("fifth_digits", digits, 16'h2305);
        check("fifth_count", digit_count, 3'd4);

        // Press bounce then release bounce on key 4
        base_strobes = strobe_cnt;
        enc.bcd_in = 4'd4;
        apply_loadn(6'b101111);
        enc.loadn_in = 1'b1;
        tick(8);
        check("bounce_press_strobes", strobe_cnt - base_strobes, 1);
        apply_loadn(6'b010000);
        enc.loadn_in = 1'b0;
        tick(8);
        check("bounce_rel_strobes", strobe_cnt - base_strobes, 1);
        check("bounce_digits", digits, 16'h3054);

        base_strobes = strobe_cnt;
        press_release(4'hB, 10, 8);
        check("invalid_strobes", strobe_cnt - base_strobes, 0);
        check("invalid_digits", digits, 16'h3054);

        // Digit changes 3 -> 8 during press debounce
        base_strobes = strobe_cnt;
        enc.bcd_in   = 4'd3;
        enc.loadn_in = 1'b1;
        tick(2);
        enc.bcd_in = 4'd8;
        tick(5);
        check("change_early_strobes", strobe_cnt - base_strobes, 0);
        tick(7);
        check("change_late_strobes", strobe_cnt - base_strobes, 1);
        enc.loadn_in = 1'b0;
        tick(8);
        check("change_digits", digits, 16'h0548);

        lock = 1'b1;
        tick(3);
        check("lock_enablen", enc.enablen, 1'b1);
        base_strobes = strobe_cnt;
        press_release(4'd9, 10, 8);
        check("lock_strobes", strobe_cnt - base_strobes, 0);
        check("lock_digits", digits, 16'h0548);
        lock = 1'b0;
        tick(3);
        check("unlock_enablen", enc.enablen, 1'b0);

        // Clear asserted on the very edge that registers the strobe
        base_strobes = strobe_cnt;
        enc.bcd_in   = 4'd6;
        enc.loadn_in = 1'b1;
        tick(5);
        clear_entry = 1'b1;
        tick(1);
        clear_entry = 1'b0;
        check("clr_strobe_digits", digits, 16'h0000);
        check("clr_strobe_count", digit_count, 3'd0);
        enc.loadn_in = 1'b0;
        tick(8);
        check("clr_strobe_hold", digits, 16'h0000);

        press_release(4'd1, 8, 8);
        check("pre_reset_digits", digits, 16'h0001);

        // Reset in the middle of a press debounce
        base_strobes = strobe_cnt;
        enc.bcd_in   = 4'd2;
        enc.loadn_in = 1'b1;
        tick(3);
        resetn = 1'b0;
        #1;
        check("midreset_digits", digits, 16'h0000);
        check("midreset_count", digit_count, 3'd0);
        check("midreset_enablen", enc.enablen, 1'b1);
        enc.loadn_in = 1'b0;
        tick(2);
        resetn = 1'b1;
        tick(10);
        check("midreset_strobes", strobe_cnt - base_strobes, 0);
        check("midreset_digits_after", digits, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
